// File: rtl/systolic_feed_ctrl.sv
// Streams len words from a synchronous word buffer into the 8-lane skew stage,
// then pushes FLUSH_LEN zero words to drain it; a 1-word hold absorbs stalls.
module systolic_feed_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned WORD_WIDTH = 8 * DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 9,
    parameter int unsigned FLUSH_LEN  = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic                  stall_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [WORD_WIDTH-1:0] rd_data_i,
    output logic                  skew_en_o,
    output logic [WORD_WIDTH-1:0] skew_word_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned FC_WIDTH = (FLUSH_LEN < 2) ? 1 : $clog2(FLUSH_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [FC_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  hold_vld_q, hold_vld_d;
    logic [WORD_WIDTH-1:0] hold_q, hold_d;

    logic rd_fire;
    logic push;
    logic zero_push;

    // Read issue and skew push are combinational on the live stall input
    always_comb begin
        rd_fire   = (state_q == FETCH) && !stall_i;
        push      = !stall_i && (hold_vld_q || pend_vld_q || (state_q == FLUSH));
        zero_push = push && !hold_vld_q && !pend_vld_q && (state_q == FLUSH);
    end

    always_comb begin
        rd_en_o     = rd_fire;
        rd_addr_o   = (state_q == FETCH) ? ADDR_WIDTH'(base_q + ADDR_WIDTH'(rd_cnt_q)) : '0;
        skew_en_o   = push;
        skew_word_o = hold_vld_q ? hold_q : (pend_vld_q ? rd_data_i : '0);
        busy_o      = (state_q == FETCH) || (state_q == FLUSH);
        done_o      = (state_q == DONE);
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        rd_cnt_d    = rd_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pend_vld_d  = rd_fire;
        hold_vld_d  = hold_vld_q;
        hold_d      = hold_q;

        // Returned word that cannot be pushed is parked; the hold drains first
        if (pend_vld_q && stall_i) begin
            hold_d     = rd_data_i;
            hold_vld_d = 1'b1;
        end else if (hold_vld_q && !stall_i) begin
            hold_vld_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    base_d      = base_addr_i;
                    len_d       = len_i;
                    rd_cnt_d    = '0;
                    flush_cnt_d = '0;
                    state_d     = (len_i != '0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (rd_fire) begin
                    rd_cnt_d = LEN_WIDTH'(rd_cnt_q + LEN_WIDTH'(1));
                    if (rd_cnt_q == LEN_WIDTH'(len_q - LEN_WIDTH'(1))) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (zero_push) begin
                    flush_cnt_d = FC_WIDTH'(flush_cnt_q + FC_WIDTH'(1));
                    if (flush_cnt_q == FC_WIDTH'(FLUSH_LEN - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            flush_cnt_q <= '0;
            pend_vld_q  <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            rd_cnt_q    <= rd_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            pend_vld_q  <= pend_vld_d;
            hold_vld_q  <= hold_vld_d;
            hold_q      <= hold_d;
        end
    end

endmodule

// File: doc/systolic_feed_ctrl.md
Name: systolic_feed_ctrl

Overview:
- Sequences one operand stream from a synchronous on-chip word buffer into the 8-lane skew shift-register stage that feeds the systolic array.
- On start, issues len consecutive buffer reads and forwards each returned word to the skew stage.
- Then pushes 7 zero words so the last real word fully drains through the skew pipeline, and pulses done.
- Supports downstream stall with a 1-word hold register. Sits between the tile scheduler and the skew stage.

Parameters:
- DATA_WIDTH, 16, width of one lane element.
- WORD_WIDTH, 8*DATA_WIDTH, width of one 8-lane word.
- ADDR_WIDTH, 8, buffer address width.
- LEN_WIDTH, 9, width of the word count (0..256).
- FLUSH_LEN, 7, number of zero words pushed after the data (lanes-1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- start_i  in  1  start request; accepted only in IDLE
- base_addr_i  in  ADDR_WIDTH  first buffer address; captured on accepted start
- len_i  in  LEN_WIDTH  number of words to stream; captured on accepted start
- stall_i  in  1  freeze: no read issue, no skew push
- rd_en_o  out  1  buffer read strobe
- rd_addr_o  out  ADDR_WIDTH  buffer read address
- rd_data_i  in  WORD_WIDTH  buffer data, valid exactly 1 cycle after rd_en_o
- skew_en_o  out  1  enable to skew stage (shift one word)
- skew_word_o  out  WORD_WIDTH  word presented to skew stage
- busy_o  out  1  high from the cycle after an accepted start until done_o
- done_o  out  1  1-cycle completion pulse

Behaviour:
- Reset is asynchronous, active-low, on rst_ni; clock is clk_i. During reset all state is cleared: state=IDLE, counters=0, pend_vld=0, hold_vld=0, hold=0.
- Reset values of outputs: rd_en_o=0, rd_addr_o=0, skew_en_o=0, skew_word_o=0, busy_o=0, done_o=0.
- Reset asserted mid-operation aborts immediately; no done_o is produced.
- States: IDLE, FETCH, FLUSH, DONE.
- IDLE:
  - start_i=1 with len_i≠0 → FETCH.
  - start_i=1 with len_i=0 → DONE; no reads and no pushes occur.
  - start_i is ignored in every other state.
- FETCH:
  - rd_en_o = !stall_i. rd_addr_o = base + rd_cnt, modulo 2^ADDR_WIDTH (wraps).
  - rd_cnt increments on each issued read.
  - The cycle that issues read len-1 transitions to FLUSH.
- In-flight tracking:
  - pend_vld is a registered copy of rd_en_o, marking returned data.
  - If pend_vld && stall_i, rd_data_i is latched into hold and hold_vld is set.
  - hold_vld and pend_vld are never both 1.
- Skew output (combinational):
  - skew_word_o = hold_vld ? hold : pend_vld ? rd_data_i : 0.
  - skew_en_o = !stall_i && (hold_vld || pend_vld || state==FLUSH).
  - hold_vld clears on a push taken from hold.
- FLUSH:
  - No reads are issued.
  - A push with hold_vld=0 and pend_vld=0 is a zero push and increments flush_cnt.
  - Pushes of the pending last word do not count.
  - The cycle of the FLUSH_LEN-th zero push transitions to DONE.
- DONE: done_o=1 for exactly one cycle, independent of stall_i; then IDLE.
- busy_o = (state==FETCH || state==FLUSH), registered state decode.
- Latency with len=N, no stall, start sampled at edge 0:
  - reads in cycles 1..N;
  - skew_en_o high in cycles 2..N+8 (N data pushes, then 7 zero pushes);
  - done_o in cycle N+9.
- Every word of the stream is pushed exactly once, in address order, regardless of the stall pattern.

Test Plan:
- base=0x10, len=8, no stall → rd_addr 0x10..0x17 in cycles 1..8; skew_en_o high in cycles 2..16; words D0..D7 in cycles 2..9, then 7 zero words; done_o in cycle 17 only; busy_o high in cycles 1..16.
- len=1, base=0x05 → one read at 0x05; 8 pushes (D0 + 7 zeros); done_o at cycle 10.
- len=0 → no rd_en_o, no skew_en_o; done_o in cycle 1; busy_o stays 0.
- len=4; stall_i high for 3 cycles starting the cycle after the 2nd read → D1 captured in hold; no rd_en_o or skew_en_o while stalled; D1 pushed first after release, then D2, D3; total 4 data + 7 zero pushes; done_o delayed by exactly 3 cycles.
- base=0xFE, len=4 → addresses 0xFE, 0xFF, 0x00, 0x01. A second start_i during FETCH is ignored, with no change to the count or addresses.
- rst_ni low during FLUSH → all outputs 0 immediately, no done_o. Then start len=2 → a normal 2+7 push sequence.
